// File: rtl/mips_ctrl_pipe_if.sv
// mips_ctrl_pipe_if: D-stage instruction fields in, decode/hazard/pipeline
// control out.
//   master : datapath side (drives the D fields, consumes the controls)
//   slave  : control unit side
interface mips_ctrl_pipe_if #(parameter int REG_AW = 5);
  // D-stage inputs
  logic [5:0]        opcode_D;
  logic [5:0]        funct_D;
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic [REG_AW-1:0] rd_D;
  logic              equal_D;
  // D-stage decode
  logic              pcsrc_D;
  logic              jump_D;
  logic              branch_D;
  logic              ext_zero_D;
  logic              illegal_D;
  // hazard controls
  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              flush_E;
  logic              forwardA_D;
  logic              forwardB_D;
  // E stage
  logic              alusrc_E;
  logic [2:0]        alucontrol_E;
  logic [1:0]        forwardA_E;
  logic [1:0]        forwardB_E;
  // M stage
  logic              regwrite_M;
  logic              memwrite_M;
  logic              memread_M;
  logic              memtoreg_M;
  logic [REG_AW-1:0] writereg_M;
  // W stage
  logic              regwrite_W;
  logic              memtoreg_W;
  logic [REG_AW-1:0] writereg_W;

  modport master (
    output opcode_D, funct_D, rs_D, rt_D, rd_D, equal_D,
    input  pcsrc_D, jump_D, branch_D, ext_zero_D, illegal_D,
    input  stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D,
    input  alusrc_E, alucontrol_E, forwardA_E, forwardB_E,
    input  regwrite_M, memwrite_M, memread_M, memtoreg_M, writereg_M,
    input  regwrite_W, memtoreg_W, writereg_W
  );

  modport slave (
    input  opcode_D, funct_D, rs_D, rt_D, rd_D, equal_D,
    output pcsrc_D, jump_D, branch_D, ext_zero_D, illegal_D,
    output stall_F, stall_D, flush_D, flush_E, forwardA_D, forwardB_D,
    output alusrc_E, alucontrol_E, forwardA_E, forwardB_E,
    output regwrite_M, memwrite_M, memread_M, memtoreg_M, writereg_M,
    output regwrite_W, memtoreg_W, writereg_W
  );
endinterface

// File: rtl/mips_ctrl_pipe.sv
// mips_ctrl_pipe: pipelined control + hazard unit for a 5-stage MIPS core.
//   clk, rst_n : clock, async active-low reset
//   bus        : mips_ctrl_pipe_if.slave -- D fields in; D decode, stall/
//                flush/forward selects and E/M/W control bits out.
// Params: REG_AW register-address width; FWD_EN 1 = forwarding with minimal
// stalls, 0 = no forwarding, stall on every RAW hazard against E or M.
module mips_ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_ctrl_pipe_if.slave    bus
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             c;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } de_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] wr;
  } em_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] wr;
  } mw_t;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  // ---------------- D-stage decode ----------------
  ctrl_t dec;
  logic  branch, is_bne, jump, ext_zero, illegal;

  always_comb begin
    dec      = '0;
    branch   = 1'b0;
    is_bne   = 1'b0;
    jump     = 1'b0;
    ext_zero = 1'b0;
    illegal  = 1'b0;
    case (bus.opcode_D)
      6'b000000: begin
        dec.regwrite = 1'b1;
        dec.regdst   = 1'b1;
        case (bus.funct_D)
          6'b100010: dec.alucontrol = ALU_SUB;
          6'b100100: dec.alucontrol = ALU_AND;
          6'b100101: dec.alucontrol = ALU_OR;
          6'b101010: dec.alucontrol = ALU_SLT;
          default:   dec.alucontrol = ALU_ADD;
        endcase
      end
      6'b100011: begin
        dec.regwrite   = 1'b1;
        dec.alusrc     = 1'b1;
        dec.memtoreg   = 1'b1;
        dec.memread    = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      6'b101011: begin
        dec.alusrc     = 1'b1;
        dec.memwrite   = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      6'b000100: begin
        branch         = 1'b1;
        dec.alucontrol = ALU_SUB;
      end
      6'b000101: begin
        branch         = 1'b1;
        is_bne         = 1'b1;
        dec.alucontrol = ALU_SUB;
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        case (bus.opcode_D[2:0])
          3'b010:  dec.alucontrol = ALU_SLT;
          3'b100:  begin dec.alucontrol = ALU_AND; ext_zero = 1'b1; end
          3'b101:  begin dec.alucontrol = ALU_OR;  ext_zero = 1'b1; end
          default: dec.alucontrol = ALU_ADD;
        endcase
      end
      6'b000010: jump = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

  // ---------------- pipeline registers ----------------
  de_t e_q;
  em_t m_q;
  mw_t w_q;
  logic              stall;
  logic [REG_AW-1:0] writereg_E;

  assign writereg_E = e_q.c.regdst ? e_q.rd : e_q.rt;

  // A stall turns the E slot into a bubble while D is held by the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     e_q <= '0;
    else if (stall) e_q <= '0;
    else            e_q <= '{c: dec, rs: bus.rs_D, rt: bus.rt_D, rd: bus.rd_D};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= '{regwrite: e_q.c.regwrite, memtoreg: e_q.c.memtoreg,
               memread: e_q.c.memread, memwrite: e_q.c.memwrite, wr: writereg_E};
      w_q <= '{regwrite: m_q.regwrite, memtoreg: m_q.memtoreg, wr: m_q.wr};
    end
  end

  // ---------------- hazard / forwarding ----------------
  logic       lwstall, branchstall, e_dep, m_dep;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;

  always_comb begin
    lwstall     = 1'b0;
    branchstall = 1'b0;
    fwd_a_d     = 1'b0;
    fwd_b_d     = 1'b0;
    fwd_a_e     = 2'b00;
    fwd_b_e     = 2'b00;
    e_dep = hit(writereg_E, bus.rs_D) | hit(writereg_E, bus.rt_D);
    m_dep = hit(m_q.wr, bus.rs_D) | hit(m_q.wr, bus.rt_D);
    if (FWD_EN) begin
      // Conservative: rt is compared even for instructions that don't read it.
      lwstall     = e_q.c.memread & e_dep;
      branchstall = branch & ((e_q.c.regwrite & e_dep) | (m_q.memread & m_dep));
      stall       = lwstall | branchstall;
      fwd_a_d     = m_q.regwrite & hit(m_q.wr, bus.rs_D);
      fwd_b_d     = m_q.regwrite & hit(m_q.wr, bus.rt_D);
      if (m_q.regwrite & hit(m_q.wr, e_q.rs))      fwd_a_e = 2'b10;
      else if (w_q.regwrite & hit(w_q.wr, e_q.rs)) fwd_a_e = 2'b01;
      if (m_q.regwrite & hit(m_q.wr, e_q.rt))      fwd_b_e = 2'b10;
      else if (w_q.regwrite & hit(w_q.wr, e_q.rt)) fwd_b_e = 2'b01;
    end else begin
      // W is safe without forwarding: the register file writes before reads.
      stall = (e_q.c.regwrite & e_dep) | (m_q.regwrite & m_dep);
    end
  end

  // Stall beats a taken branch/jump: redirect only once D is free to move.
  logic taken;
  assign taken = branch & (is_bne ? ~bus.equal_D : bus.equal_D);

  assign bus.pcsrc_D      = taken & ~stall;
  assign bus.jump_D       = jump & ~stall;
  assign bus.branch_D     = branch;
  assign bus.ext_zero_D   = ext_zero;
  assign bus.illegal_D    = illegal;
  assign bus.flush_D      = bus.pcsrc_D | bus.jump_D;
  assign bus.stall_F      = stall;
  assign bus.stall_D      = stall;
  assign bus.flush_E      = stall;
  assign bus.forwardA_D   = fwd_a_d;
  assign bus.forwardB_D   = fwd_b_d;
  assign bus.alusrc_E     = e_q.c.alusrc;
  assign bus.alucontrol_E = e_q.c.alucontrol;
  assign bus.forwardA_E   = fwd_a_e;
  assign bus.forwardB_E   = fwd_b_e;
  assign bus.regwrite_M   = m_q.regwrite;
  assign bus.memwrite_M   = m_q.memwrite;
  assign bus.memread_M    = m_q.memread;
  assign bus.memtoreg_M   = m_q.memtoreg;
  assign bus.writereg_M   = m_q.wr;
  assign bus.regwrite_W   = w_q.regwrite;
  assign bus.memtoreg_W   = w_q.memtoreg;
  assign bus.writereg_W   = w_q.wr;

endmodule

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Pipelined control and hazard unit for the five-stage MIPS core. Decodes the instruction in the Decode (D) stage, resolves branches and jumps in D, and carries control bits and destination-register tags through the E/M/W pipeline registers. Generates load-use and branch stalls, pipeline flushes and forwarding selects. Supersedes the combinational single-stage controller: adds bne/immediate-logic opcodes, internal control pipelining, hazard detection and a forwarding-disable mode.

## Interface
- REG_AW, 5: register-address width.
- FWD_EN, 1: 1 = forwarding and minimal stalls; 0 = no forwarding, stall on every RAW hazard.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode_D, funct_D  in  6 each  fields of the instruction in D.
- rs_D, rt_D, rd_D  in  REG_AW each  register fields in D.
- equal_D  in  1  1 when the forwarded D-stage operands are equal.
- pcsrc_D, jump_D, branch_D, ext_zero_D, illegal_D  out  1 each  D-stage decode outputs.
- stall_F, stall_D, flush_D, flush_E  out  1 each  hazard controls.
- forwardA_D, forwardB_D  out  1 each  branch-comparator forward from M.
- alusrc_E  out  1.
- alucontrol_E  out  3.
- forwardA_E, forwardB_E  out  2 each  ALU operand select: 00 = register file, 10 = M, 01 = W.
- regwrite_M, memwrite_M, memread_M, memtoreg_M  out  1 each.
- writereg_M  out  REG_AW.
- regwrite_W, memtoreg_W  out  1 each.
- writereg_W  out  REG_AW.

## Operation
- Decode (combinational, D stage). Alucontrol encodings: add=010, sub=110, and=000, or=001, slt=111.
  - R (000000): regwrite, regdst. funct 100000→add, 100010→sub, 100100→and, 100101→or, 101010→slt; any other funct gives alucontrol add.
  - lw (100011): regwrite, alusrc, memtoreg, memread, add.
  - sw (101011): alusrc, memwrite, add.
  - beq (000100) and bne (000101): branch_D, sub.
  - addi (001000): add. slti (001010): slt. andi (001100): and, ext_zero. ori (001101): or, ext_zero. All four: regwrite, alusrc.
  - j (000010): jump.
  - Any other opcode: all controls 0 (NOP) and illegal_D=1.
- pcsrc_D = ((beq & equal_D) | (bne & ~equal_D)) & ~stall_D. jump_D is also gated by ~stall_D.
- flush_D = pcsrc_D | jump_D. There is no delay slot.
- writereg_E = regdst_E ? rd_E : rt_E. Register 0 never matches in any hazard or forward comparison.
- FWD_EN=1:
  - lwstall = memread_E & (writereg_E==rs_D | writereg_E==rt_D). This is conservative: it does not depend on which fields the instruction uses.
  - branchstall = branch_D & ((regwrite_E & writereg_E matches rs_D/rt_D) | (memread_M & writereg_M matches rs_D/rt_D)).
  - stall = lwstall | branchstall.
  - forwardX_D = regwrite_M & writereg_M==rsX_D.
  - forwardX_E = 10 if regwrite_M & writereg_M==srcX_E; else 01 if regwrite_W & writereg_W==srcX_E; else 00. M has priority.
- FWD_EN=0:
  - stall = any (regwrite_E | regwrite_M) with a writereg matching rs_D/rt_D. W is excluded because the register file is write-before-read.
  - All forward outputs are constant 0.
- stall_F = stall_D = flush_E = stall.

## Timing
- D→E register captures decoded controls plus rs/rt/rd on every clk. flush_E or rst_n=0 loads NOP (all zero).
- E→M and M→W registers advance every cycle.
- Latency from D decode: E-stage controls after 1 clk, M after 2, W after 3.
- Stall/flush/forward outputs are combinational within the same cycle.
- Reset (asynchronous, any time, including mid-stall): every E/M/W output and writereg is 0.
  - All stall/flush/forward outputs are 0 provided the D inputs decode as NOP.
- Simultaneous stall and taken branch: stall wins. pcsrc_D=0 and flush_D=0 until the stall clears.
- A stalled instruction re-decodes each cycle; its inputs are held by the datapath.

## Test plan
- Assert rst_n=0 mid-stream, then release -> all E/M/W outputs 0 immediately; the first instruction's regwrite_W appears 3 cycles after its D cycle.
- add $3,$1,$2 then sub $4,$3,$3 -> no stall; forwardA_E=forwardB_E=10 for sub. With one intervening NOP -> 01.
- lw $2,0($1) then add $4,$2,$5 -> exactly one cycle with stall_F=stall_D=flush_E=1; then forwardA_E=01.
- beq $1,$1 with no hazard, equal_D=1 -> pcsrc_D=1, flush_D=1 in the same cycle. bne with equal_D=1 -> pcsrc_D=0.
- add $3 then beq $3,$0 -> one branchstall cycle, then forwardA_D=1. lw $3 then beq $3 -> two stall cycles.
- FWD_EN=0, add $3 then add $5,$3,$3 -> two stall cycles, all forward outputs 0. Opcode 111111 -> illegal_D=1 and NOP controls propagate.
